// File: rtl/key_highlight_mixer_if.sv
// key_highlight_mixer_if: sprite/timing inputs and mixed pixel/timing/note outputs of the key mixer
interface key_highlight_mixer_if #(parameter int NUM_KEYS = 8);
  logic [NUM_KEYS*24-1:0] key_pixels;
  logic [NUM_KEYS-1:0] key_down;
  logic hsync_in;
  logic vsync_in;
  logic blank_in;
  logic [23:0] pixel;
  logic hsync_out;
  logic vsync_out;
  logic blank_out;
  logic [NUM_KEYS-1:0] note_on;
  modport master(
    output key_pixels, key_down, hsync_in, vsync_in, blank_in,
    input pixel, hsync_out, vsync_out, blank_out, note_on
  );
  modport slave(
    input key_pixels, key_down, hsync_in, vsync_in, blank_in,
    output pixel, hsync_out, vsync_out, blank_out, note_on
  );
endinterface

// File: rtl/key_highlight_mixer.sv
// key_highlight_mixer: merges key sprites, tints pressed keys, 2-cycle aligned VGA output and note-on pulses
// HIGHLIGHT_FADE_EN: highlight fades one step every FADE_DIV frames after release (else drops at once)
module key_highlight_mixer #(
  parameter int NUM_KEYS = 8,
  parameter logic [23:0] HIGHLIGHT_COLOR = 24'hFF_00_00
`ifdef HIGHLIGHT_FADE_EN
  , parameter int FADE_DIV = 2
`endif
) (
  input logic vclock,
  input logic reset_n,
  key_highlight_mixer_if.slave bus
);
  logic vs_q;
  logic [NUM_KEYS-1:0] down_q;
  logic [4:0] inten [NUM_KEYS];
  logic [4:0] nxt [NUM_KEYS];
  logic tick;
  assign tick = reset_n & vs_q & ~bus.vsync_in;
  assign bus.note_on = tick ? bus.key_down & ~down_q : '0;
  always_ff @(posedge vclock) begin
    if (!reset_n) begin
      vs_q <= 1'b1;
      down_q <= '0;
    end else begin
      vs_q <= bus.vsync_in;
      if (tick) down_q <= bus.key_down;
    end
  end
`ifdef HIGHLIGHT_FADE_EN
  logic [7:0] div;
  logic step;
  assign step = ~|bus.key_down && div == 8'(FADE_DIV - 1);
  always_ff @(posedge vclock) begin
    if (!reset_n) div <= '0;
    else if (tick) div <= (|bus.key_down || step) ? '0 : div + 8'd1;
  end
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++)
      nxt[k] = bus.key_down[k] ? 5'd16 : (step && inten[k] != 5'd0) ? inten[k] - 5'd1 : inten[k];
  end
`else
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++)
      nxt[k] = bus.key_down[k] ? 5'd16 : 5'd0;
  end
`endif
  always_ff @(posedge vclock) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_KEYS; k++) inten[k] <= '0;
    end else if (tick) begin
      inten <= nxt;
    end
  end
  logic [23:0] sel_pix;
  logic [4:0] sel_i;
  // descending scan so the lowest covering key wins
  always_comb begin
    sel_pix = '0;
    sel_i = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--)
      if (bus.key_pixels[24*k +: 24] != 24'd0) begin
        sel_pix = bus.key_pixels[24*k +: 24];
        sel_i = inten[k];
      end
  end
  logic [23:0] base_q;
  logic [4:0] i_q;
  logic hs_q, vs1_q, bl_q;
  always_ff @(posedge vclock) begin
    if (!reset_n) begin
      base_q <= '0;
      i_q <= '0;
      hs_q <= 1'b1;
      vs1_q <= 1'b1;
      bl_q <= 1'b1;
    end else begin
      base_q <= sel_pix;
      i_q <= sel_i;
      hs_q <= bus.hsync_in;
      vs1_q <= bus.vsync_in;
      bl_q <= bus.blank_in;
    end
  end
  logic [23:0] mix;
  always_comb begin
    mix = '0;
    for (int c = 0; c < 3; c++)
      mix[8*c +: 8] = 8'((12'(base_q[8*c +: 8]) * 12'(5'd16 - i_q)
                        + 12'(HIGHLIGHT_COLOR[8*c +: 8]) * 12'(i_q)) >> 4);
  end
  always_ff @(posedge vclock) begin
    if (!reset_n) begin
      bus.pixel <= '0;
      bus.hsync_out <= 1'b1;
      bus.vsync_out <= 1'b1;
      bus.blank_out <= 1'b1;
    end else begin
      bus.pixel <= (bl_q || base_q == 24'd0) ? 24'd0 : mix;
      bus.hsync_out <= hs_q;
      bus.vsync_out <= vs1_q;
      bus.blank_out <= bl_q;
    end
  end
endmodule

// File: tb/tb_key_highlight_mixer.sv
// tb_key_highlight_mixer: vector table, directed press/fade/reset sequences and random stimulus vs a reference model
module tb_key_highlight_mixer;
  localparam int N = 8;
  localparam logic [23:0] HL = 24'hFF0000;
  localparam int FADE_DIV = 2;
  logic vclock = 1'b0;
  logic reset_n;
  key_highlight_mixer_if bus();
  key_highlight_mixer dut(.vclock(vclock), .reset_n(reset_n), .bus(bus));
  always #5 vclock = ~vclock;

  typedef struct { logic [23:0] pix; logic hs; logic vs; logic bl; } out_t;
  typedef struct { logic [N*24-1:0] kp; logic bl; logic [23:0] exp; } vec_t;
  out_t hist, oexp;
  int inten [N];
  int div;
  logic vs_prev;
  logic [N-1:0] prev_down;
  int total = 0;
  int bad = 0;

  function automatic int mixc(int b, int h, int i);
    return (b * (16 - i) + h * i) / 16;
  endfunction

  function automatic logic [23:0] expect_pix();
    logic [23:0] b, r, hl;
    hl = HL;
    for (int k = 0; k < N; k++) begin
      b = bus.key_pixels[24*k +: 24];
      if (b != 0) begin
        for (int c = 0; c < 3; c++) r[8*c +: 8] = 8'(mixc(int'(b[8*c +: 8]), int'(hl[8*c +: 8]), inten[k]));
        return bus.blank_in ? 24'd0 : r;
      end
    end
    return 24'd0;
  endfunction

  function automatic logic [N-1:0] exp_note();
    return (reset_n && vs_prev && !bus.vsync_in) ? bus.key_down & ~prev_down : '0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit reload, stp;
    if (!reset_n) begin
      hist = '{pix: 24'd0, hs: 1'b1, vs: 1'b1, bl: 1'b1};
      oexp = hist;
      vs_prev = 1'b1;
      prev_down = '0;
      div = 0;
      for (int k = 0; k < N; k++) inten[k] = 0;
    end else begin
      oexp = hist;
      hist = '{pix: expect_pix(), hs: bus.hsync_in, vs: bus.vsync_in, bl: bus.blank_in};
      if (vs_prev && !bus.vsync_in) begin
        reload = |bus.key_down;
        stp = !reload && div == FADE_DIV - 1;
        for (int k = 0; k < N; k++) begin
`ifdef HIGHLIGHT_FADE_EN
          if (bus.key_down[k]) inten[k] = 16;
          else if (stp && inten[k] > 0) inten[k] = inten[k] - 1;
`else
          inten[k] = bus.key_down[k] ? 16 : 0;
`endif
        end
        div = reload ? 0 : (div + 1) % FADE_DIV;
        prev_down = bus.key_down;
      end
      vs_prev = bus.vsync_in;
    end
  endtask

  task automatic cycle();
    @(negedge vclock);
    chk("pixel", 32'(bus.pixel), 32'(oexp.pix));
    chk("hsync_out", 32'(bus.hsync_out), 32'(oexp.hs));
    chk("vsync_out", 32'(bus.vsync_out), 32'(oexp.vs));
    chk("blank_out", 32'(bus.blank_out), 32'(oexp.bl));
    chk("note_on", 32'(bus.note_on), 32'(exp_note()));
    @(posedge vclock);
    model_edge();
    #1;
  endtask

  task automatic frame();
    bus.vsync_in = 1'b1;
    cycle();
    bus.vsync_in = 1'b0;
    cycle();
  endtask

  task automatic rand_in();
    for (int k = 0; k < N; k++)
      bus.key_pixels[24*k +: 24] = ($urandom_range(0, 1) == 0) ? 24'd0 : 24'($urandom);
    bus.hsync_in = 1'($urandom);
    bus.vsync_in = 1'($urandom);
    bus.blank_in = ($urandom_range(0, 3) == 0);
    bus.key_down = N'($urandom);
  endtask

  vec_t tv [6];

  initial begin
    tv[0] = '{kp: {168'h0, 24'hFFFFFF}, bl: 1'b0, exp: 24'hFFFFFF};
    tv[1] = '{kp: {96'h0, 24'hABCDEF, 24'h0, 24'h123456, 24'h0}, bl: 1'b0, exp: 24'h123456};
    tv[2] = '{kp: {96'h0, 24'hABCDEF, 72'h0}, bl: 1'b0, exp: 24'hABCDEF};
    tv[3] = '{kp: {168'h0, 24'hFFFFFF}, bl: 1'b1, exp: 24'h000000};
    tv[4] = '{kp: 192'h0, bl: 1'b0, exp: 24'h000000};
    tv[5] = '{kp: {24'h010203, 168'h0}, bl: 1'b0, exp: 24'h010203};

    reset_n = 1'b0;
    rand_in();
    @(posedge vclock);
    model_edge();
    #1;
    for (int n = 0; n < 3; n++) begin
      rand_in();
      cycle();
    end
    #1;
    chk("rst_pixel", 32'(bus.pixel), 32'h0);
    chk("rst_hsync", 32'(bus.hsync_out), 32'h1);
    chk("rst_vsync", 32'(bus.vsync_out), 32'h1);
    chk("rst_blank", 32'(bus.blank_out), 32'h1);
    chk("rst_note", 32'(bus.note_on), 32'h0);

    bus.key_down = '0;
    bus.vsync_in = 1'b1;
    bus.hsync_in = 1'b1;
    bus.blank_in = 1'b0;
    bus.key_pixels = {168'h0, 24'hFFFFFF};
    reset_n = 1'b1;
    cycle();
    cycle();
    chk("first_valid", 32'(bus.pixel), 32'hFFFFFF);
    bus.hsync_in = 1'b0;
    cycle();
    chk("hsync_lag1", 32'(bus.hsync_out), 32'h1);
    cycle();
    chk("hsync_lag2", 32'(bus.hsync_out), 32'h0);
    bus.hsync_in = 1'b1;

    for (int i = 0; i < 6; i++) begin
      bus.key_pixels = tv[i].kp;
      bus.blank_in = tv[i].bl;
      cycle();
      cycle();
      chk($sformatf("vec%0d", i), 32'(bus.pixel), 32'(tv[i].exp));
    end

    bus.blank_in = 1'b0;
    bus.key_pixels = '0;
    bus.key_down = 8'b0000_0100;
    bus.vsync_in = 1'b1;
    cycle();
    bus.vsync_in = 1'b0;
    #1;
    chk("press_note", 32'(bus.note_on), 32'h04);
    cycle();
    #1;
    chk("press_note_once", 32'(bus.note_on), 32'h0);
    bus.key_pixels[24*2 +: 24] = 24'hFFFFFF;
    cycle();
    cycle();
    chk("press_tint", 32'(bus.pixel), 32'hFF0000);
    bus.key_pixels[24*2 +: 24] = 24'h000000;
    cycle();
    cycle();
    chk("press_black", 32'(bus.pixel), 32'h0);

    bus.key_pixels[24*2 +: 24] = 24'hFFFFFF;
    bus.key_down = '0;
    for (int t = 1; t <= 32; t++) begin
      frame();
      cycle();
      cycle();
`ifdef HIGHLIGHT_FADE_EN
      if (t == 1) chk("fade_t1", 32'(bus.pixel), 32'hFF0000);
      if (t == 16) chk("fade_half", 32'(bus.pixel), 32'hFF7F7F);
      if (t == 32) chk("fade_done", 32'(bus.pixel), 32'hFFFFFF);
`else
      if (t == 1) chk("release_t1", 32'(bus.pixel), 32'hFFFFFF);
      if (t == 32) chk("release_t32", 32'(bus.pixel), 32'hFFFFFF);
`endif
    end

    bus.key_down = 8'b0000_0100;
    frame();
    bus.key_down = '0;
    for (int t = 0; t < 12; t++) frame();
    cycle();
    cycle();
`ifdef HIGHLIGHT_FADE_EN
    chk("fade_at10", 32'(bus.pixel), 32'hFF5F5F);
`else
    chk("released_white", 32'(bus.pixel), 32'hFFFFFF);
`endif
    bus.vsync_in = 1'b1;
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    cycle();
    cycle();
    chk("rst_untint", 32'(bus.pixel), 32'hFFFFFF);

    bus.key_down = 8'b0000_0100;
    cycle();
    bus.vsync_in = 1'b0;
    #1;
    chk("hold_note", 32'(bus.note_on), 32'h04);
    cycle();
    bus.vsync_in = 1'b1;
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    cycle();
    bus.vsync_in = 1'b0;
    #1;
    chk("note_after_rst", 32'(bus.note_on), 32'h04);
    cycle();
    #1;
    chk("note_after_rst_once", 32'(bus.note_on), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      for (int k = 0; k < N; k++)
        bus.key_pixels[24*k +: 24] = ($urandom_range(0, 1) == 0) ? 24'd0 : 24'($urandom);
      if ($urandom_range(0, 15) == 0) bus.key_down = N'($urandom);
      if ($urandom_range(0, 5) == 0) bus.vsync_in = ~bus.vsync_in;
      bus.hsync_in = ($urandom_range(0, 7) != 0);
      bus.blank_in = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
